// File: rtl/dca_matrix_lsu_arbiter.sv
// dca_matrix_lsu_arbiter
// Shares one DCA matrix LSU instruction port between NUM_REQ issuers.
// Grants are round-robin. Granted requester IDs are kept in issue order
// in a tag FIFO, and each LSU completion pulse is routed back to the
// requester that issued the instruction.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int BW_INST         = `BW_DCA_MATRIX_LSU_INST,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_inst_wvalid,
  output logic [NUM_REQ-1:0]         req_inst_wready,
  input  logic [NUM_REQ*BW_INST-1:0] req_inst_wdata,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       lsu_inst_wvalid,
  input  logic                       lsu_inst_wready,
  output logic [BW_INST-1:0]         lsu_inst_wdata,
  input  logic                       lsu_inst_done,
  output logic                       busy,
  output logic                       err_unexpected_done
);

  // ID width, FIFO address width, and outstanding counter width.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IW-1:0]       gnt_id_r;
  logic [IW-1:0]       gnt_id_nxt_s;
  logic [IW-1:0]       rr_ptr_r;
  logic [IW-1:0]       rr_ptr_nxt_s;
  logic [IW-1:0]       rr_sel_s;
  logic                rr_found_s;
  logic [IW:0]         rr_wrap_sum_s;
  logic [OW-1:0]       outstanding_r;
  logic [OW-1:0]       outstanding_nxt_s;
  logic [IW-1:0]       tag_mem_r [MAX_OUTSTANDING];
  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic                fifo_empty_s;
  logic [IW-1:0]       head_id_s;
  logic                grant_s;
  logic                handshake_s;
  logic                push_s;
  logic                pop_s;
  logic [NUM_REQ-1:0]  req_done_r;
  logic [NUM_REQ-1:0]  req_done_nxt_s;
  logic                err_r;
  logic                soft_rst_s;

  // Both reset sources behave identically.
  assign soft_rst_s   = rst | clear;
  // Pointers carry one extra wrap bit, so equal pointers mean empty.
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign head_id_s    = tag_mem_r[rd_ptr_r[AW-1:0]];
  assign push_s       = handshake_s;
  // A done pulse only counts when a tag is already queued.
  assign pop_s        = lsu_inst_done & ~fifo_empty_s;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    logic [IW:0] sum_v;
    logic [IW:0] cand_v;
    logic        hit_v;
    rr_found_s = 1'b0;
    rr_sel_s   = {IW{1'b0}};
    sum_v      = {(IW+1){1'b0}};
    cand_v     = {(IW+1){1'b0}};
    hit_v      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_v  = {1'b0, rr_ptr_r} + (IW+1)'(k);
      cand_v = (sum_v >= (IW+1)'(NUM_REQ)) ? (sum_v - (IW+1)'(NUM_REQ)) : sum_v;
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_v      = ~rr_found_s & (cand_v == (IW+1)'(i)) & req_inst_wvalid[i];
        rr_sel_s   = hit_v ? IW'(i) : rr_sel_s;
        rr_found_s = rr_found_s | hit_v;
      end
    end
  end

  // Priority moves to the requester after the one just accepted.
  always_comb begin
    rr_wrap_sum_s = {1'b0, gnt_id_r} + (IW+1)'(1);
    if (rr_wrap_sum_s >= (IW+1)'(NUM_REQ)) begin
      rr_ptr_nxt_s = handshake_s ? {IW{1'b0}} : rr_ptr_r;
    end else begin
      rr_ptr_nxt_s = handshake_s ? rr_wrap_sum_s[IW-1:0] : rr_ptr_r;
    end
  end

  // FSM next state: grant in IDLE when allowed, wait for LSU handshake in ISSUE.
  always_comb begin
    state_nxt_s  = state_r;
    gnt_id_nxt_s = gnt_id_r;
    grant_s      = 1'b0;
    handshake_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && rr_found_s && (outstanding_r < MAX_OUT)) begin
          grant_s      = 1'b1;
          gnt_id_nxt_s = rr_sel_s;
          state_nxt_s  = ISSUE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      ISSUE: begin
        if (lsu_inst_wready) begin
          handshake_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outstanding is reserved at grant and released at each accepted completion.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({grant_s, pop_s})
      2'b10:   outstanding_nxt_s = outstanding_r + OW'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - OW'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Decode the popped head ID into the per-requester completion pulse.
  always_comb begin
    req_done_nxt_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_done_nxt_s[i] = pop_s & (head_id_s == IW'(i));
    end
  end

  // Accept and data steering toward the granted requester while in ISSUE.
  always_comb begin
    req_inst_wready = {NUM_REQ{1'b0}};
    lsu_inst_wdata  = {BW_INST{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_inst_wready[i] = (state_r == ISSUE) & (gnt_id_r == IW'(i)) & lsu_inst_wready;
      lsu_inst_wdata     = ((state_r == ISSUE) && (gnt_id_r == IW'(i))) ?
                           req_inst_wdata[i*BW_INST +: BW_INST] : lsu_inst_wdata;
    end
  end

  // FSM state, grant ID, priority pointer and outstanding counter.
  always_ff @(posedge clk) begin
    if (soft_rst_s) begin
      state_r       <= IDLE;
      gnt_id_r      <= {IW{1'b0}};
      rr_ptr_r      <= {IW{1'b0}};
      outstanding_r <= {OW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      gnt_id_r      <= gnt_id_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      outstanding_r <= outstanding_nxt_s;
    end
  end

  // Tag FIFO pointers; push on handshake, pop on accepted completion.
  always_ff @(posedge clk) begin
    if (soft_rst_s) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + (AW+1)'(1)) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + (AW+1)'(1)) : rd_ptr_r;
    end
  end

  // Tag FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r[AW-1:0]] <= gnt_id_r;
    end
  end

  // Registered completion pulse and sticky unexpected-done flag.
  always_ff @(posedge clk) begin
    if (soft_rst_s) begin
      req_done_r <= {NUM_REQ{1'b0}};
      err_r      <= 1'b0;
    end else begin
      req_done_r <= req_done_nxt_s;
      err_r      <= err_r | (lsu_inst_done & fifo_empty_s);
    end
  end

  assign lsu_inst_wvalid     = (state_r == ISSUE);
  assign busy                = (state_r == ISSUE) | (outstanding_r != {OW{1'b0}});
  assign req_done            = req_done_r;
  assign err_unexpected_done = err_r;

endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// Bench for dca_matrix_lsu_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model of the arbiter.
module tb_dca_matrix_lsu_arbiter;
  localparam int N  = 3;
  localparam int BW = 8;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst, clear, enable;
  logic [N-1:0]  valid;
  logic [N-1:0]  wready;
  logic [N*BW-1:0] wdata;
  logic [N-1:0]  done_o;
  logic          lsu_wvalid, lsu_wready, lsu_done, busy, err;
  logic [BW-1:0] lsu_wdata;

  always #5 clk = ~clk;

  dca_matrix_lsu_arbiter #(.NUM_REQ(N), .BW_INST(BW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .req_inst_wvalid(valid), .req_inst_wready(wready), .req_inst_wdata(wdata),
    .req_done(done_o), .lsu_inst_wvalid(lsu_wvalid), .lsu_inst_wready(lsu_wready),
    .lsu_inst_wdata(lsu_wdata), .lsu_inst_done(lsu_done), .busy(busy),
    .err_unexpected_done(err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_issue   = 1'b0;
  int m_gnt     = 0;
  int m_prio    = 0;
  bit m_err     = 1'b0;
  int m_done_id = -1;
  int m_acc_id  = -1;
  int m_tags[$];

  function automatic int pick(int prio, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(prio + k) % N]) return (prio + k) % N;
    end
    return -1;
  endfunction

  // Model advances on each rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    if (rst || clear) begin
      m_issue   <= 1'b0;
      m_prio    <= 0;
      m_err     <= 1'b0;
      m_done_id <= -1;
      m_acc_id  <= -1;
      m_tags.delete();
    end else begin
      m_acc_id <= -1;
      if (m_issue) begin
        if (lsu_wready) begin
          m_issue  <= 1'b0;
          m_acc_id <= m_gnt;
          m_prio   <= (m_gnt + 1) % N;
        end
      end else if (enable && valid != '0 && m_tags.size() < MO) begin
        m_issue <= 1'b1;
        m_gnt   <= pick(m_prio, valid);
      end
      if (lsu_done) begin
        if (m_tags.size() > 0) m_done_id <= m_tags.pop_front();
        else begin
          m_err     <= 1'b1;
          m_done_id <= -1;
        end
      end else begin
        m_done_id <= -1;
      end
      if (m_issue && lsu_wready) m_tags.push_back(m_gnt);
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lsu_wvalid", 32'(lsu_wvalid), 32'(m_issue));
      chk("lsu_wdata", 32'(lsu_wdata), m_issue ? 32'(wdata[m_gnt*BW +: BW]) : 32'd0);
      chk("req_wready", 32'(wready), (m_issue && lsu_wready) ? (32'd1 << m_gnt) : 32'd0);
      chk("req_done", 32'(done_o), (m_done_id >= 0) ? (32'd1 << m_done_id) : 32'd0);
      chk("busy", 32'(busy), 32'(m_issue || m_tags.size() != 0));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  function automatic int oh_id(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; valid = '0; lsu_done = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  int acc_log[$];
  int done_log[$];
  int due[$];
  int nacc[N];
  int acc_cnt;
  int pend;

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1; valid = '0; wdata = '0;
    lsu_wready = 1'b0; lsu_done = 1'b0;
    cyc();
    chk_en = 1'b1;
    chk("rst_wvalid", 32'(lsu_wvalid), 32'd0);
    chk("rst_wdata", 32'(lsu_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cyc();

    // Single request from requester 0.
    wdata[0 +: BW] = 8'hA5; valid = 3'b001; lsu_wready = 1'b1;
    cyc();
    chk("single_wvalid", 32'(lsu_wvalid), 32'd1);
    chk("single_wdata", 32'(lsu_wdata), 32'hA5);
    chk("single_wready", 32'(wready), 32'b001);
    cyc();
    valid = '0;
    chk("single_idle", 32'(lsu_wvalid), 32'd0);
    chk("single_busy_out", 32'(busy), 32'd1);
    lsu_done = 1'b1;
    cyc();
    lsu_done = 1'b0;
    chk("single_done", 32'(done_o), 32'b001);
    chk("single_busy_end", 32'(busy), 32'd0);
    cyc();
    chk("single_done_off", 32'(done_o), 32'd0);

    // Round-robin between requesters 0 and 1, done 3 cycles after each accept.
    do_reset();
    valid = 3'b011; lsu_wready = 1'b1;
    for (int i = 0; i < N; i++) nacc[i] = 0;
    for (int c = 0; c < 40 && done_log.size() < 4; c++) begin
      if (done_o != '0) done_log.push_back(oh_id(done_o));
      for (int i = 0; i < N; i++) begin
        if (nacc[i] >= 2) valid[i] = 1'b0;
      end
      lsu_done = (due.size() > 0 && due[0] == c);
      if (lsu_done) void'(due.pop_front());
      #1;
      if (wready != '0) begin
        acc_log.push_back(oh_id(wready));
        nacc[oh_id(wready)]++;
        due.push_back(c + 3);
      end
      cyc();
    end
    lsu_done = 1'b0;
    chk("rr_accepts", 32'(acc_log.size()), 32'd4);
    chk("rr_dones", 32'(done_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_order", (k < acc_log.size()) ? 32'(acc_log[k]) : 32'd99, 32'(k % 2));
      chk("rr_done_order", (k < done_log.size()) ? 32'(done_log[k]) : 32'd99, 32'(k % 2));
    end

    // Backpressure while requester 1 holds the grant.
    do_reset();
    wdata[BW +: BW] = 8'h3C; valid = 3'b010; lsu_wready = 1'b0;
    cyc();
    wdata[0 +: BW] = 8'h11; valid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      chk("bp_wvalid", 32'(lsu_wvalid), 32'd1);
      chk("bp_wdata", 32'(lsu_wdata), 32'h3C);
      chk("bp_wready", 32'(wready), 32'd0);
      cyc();
    end
    lsu_wready = 1'b1;
    #1;
    chk("bp_release", 32'(wready), 32'b010);
    cyc();
    valid = 3'b001;
    cyc();
    chk("bp_next_wdata", 32'(lsu_wdata), 32'h11);
    chk("bp_next_wready", 32'(wready), 32'b001);
    cyc();
    valid = '0;
    lsu_done = 1'b1;
    cyc();
    cyc();
    lsu_done = 1'b0;
    cyc();

    // Outstanding limit with no completions.
    do_reset();
    valid = 3'b100; wdata[2*BW +: BW] = 8'h40; lsu_wready = 1'b1;
    acc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (wready[2]) begin
        acc_cnt++;
        cyc();
        wdata[2*BW +: BW] = BW'($urandom);
      end else begin
        cyc();
      end
    end
    chk("lim_accepts", 32'(acc_cnt), 32'd4);
    chk("lim_idle", 32'(lsu_wvalid), 32'd0);
    chk("lim_busy", 32'(busy), 32'd1);
    lsu_done = 1'b1;
    cyc();
    lsu_done = 1'b0;
    chk("lim_wait", 32'(lsu_wvalid), 32'd0);
    cyc();
    chk("lim_fifth", 32'(lsu_wvalid), 32'd1);
    cyc();
    valid = '0;
    lsu_done = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    lsu_done = 1'b0;
    cyc();
    chk("lim_drained", 32'(busy), 32'd0);

    // Unexpected completion, then enable gating.
    do_reset();
    lsu_done = 1'b1;
    cyc();
    lsu_done = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_done", 32'(done_o), 32'd0);
    cyc(); cyc();
    chk("err_sticky", 32'(err), 32'd1);
    enable = 1'b0; valid = 3'b001; wdata[0 +: BW] = 8'h77; lsu_wready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("en_block", 32'(lsu_wvalid), 32'd0);
    end
    enable = 1'b1;
    cyc();
    chk("en_grant", 32'(lsu_wvalid), 32'd1);
    enable = 1'b0; lsu_wready = 1'b1;
    #1;
    chk("en_finish", 32'(wready), 32'b001);
    cyc();
    valid = '0;
    chk("en_idle", 32'(lsu_wvalid), 32'd0);
    chk("en_busy", 32'(busy), 32'd1);
    lsu_done = 1'b1;
    cyc();
    lsu_done = 1'b0;
    chk("en_done", 32'(done_o), 32'b001);
    chk("en_err_kept", 32'(err), 32'd1);
    enable = 1'b1;

    // Reset in ISSUE with two outstanding and a done in the same cycle.
    do_reset();
    valid = 3'b001; lsu_wready = 1'b1;
    cyc(); cyc();
    valid = 3'b010; lsu_wready = 1'b0;
    cyc();
    chk("mr_wvalid", 32'(lsu_wvalid), 32'd1);
    rst = 1'b1; lsu_done = 1'b1; valid = '0;
    cyc();
    rst = 1'b0; lsu_done = 1'b0;
    chk("mr_wvalid0", 32'(lsu_wvalid), 32'd0);
    chk("mr_wdata0", 32'(lsu_wdata), 32'd0);
    chk("mr_wready0", 32'(wready), 32'd0);
    chk("mr_done0", 32'(done_o), 32'd0);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_err0", 32'(err), 32'd0);
    lsu_done = 1'b1;
    cyc();
    lsu_done = 1'b0;
    chk("mr_err_after", 32'(err), 32'd1);
    chk("mr_no_done", 32'(done_o), 32'd0);

    // Randomized traffic; the LSU side completes accepted instructions in order.
    do_reset();
    pend = 0;
    for (int c = 0; c < 4000; c++) begin
      if (clear) pend = 0;
      else begin
        if (lsu_done && pend > 0) pend--;
        if (m_acc_id >= 0) pend++;
      end
      for (int i = 0; i < N; i++) begin
        if (valid[i] && m_acc_id == i) begin
          valid[i] = 1'($urandom_range(0, 1));
          wdata[i*BW +: BW] = BW'($urandom);
        end else if (!valid[i] && $urandom_range(0, 2) == 0) begin
          valid[i] = 1'b1;
          wdata[i*BW +: BW] = BW'($urandom);
        end
      end
      lsu_wready = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 7) != 0);
      lsu_done   = (pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      clear      = ($urandom_range(0, 149) == 0);
      cyc();
    end
    clear = 1'b0; valid = '0; lsu_done = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
